cache_ctrl_dm: RTL
==================

Name: cache_ctrl_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache controller.
- Next generation of the memory_system block: line size, set count and widths are parameters, and it talks to backing memory over a variable-latency handshake instead of a fixed-latency memory.
- Sits between the pipeline MEM stage and main memory.
- Raises cache_miss_stall to freeze the pipeline while it fills a line or completes a write-through.

Parameters:
- DWIDTH, 16, data word width in bits.
- AWIDTH, 16, byte address width.
- LINE_WORDS, 8, words per cache line; power of 2, ≥2.
- NUM_SETS, 32, number of lines; power of 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- mem_en  in  1  access enable.
- mem_read  in  1  read request (qualified by mem_en).
- mem_write  in  1  write request (qualified by mem_en); has priority over mem_read.
- addr_in  in  AWIDTH  byte address; bit 0 ignored.
- data_in  in  DWIDTH  write data.
- data_out  out  DWIDTH  read data.
- cache_miss_stall  out  1  pipeline must hold the request stable while this is 1.
- mm_req  out  1  backing-memory request strobe.
- mm_we  out  1  1 = write, 0 = read.
- mm_addr  out  AWIDTH  word-aligned byte address to backing memory.
- mm_wdata  out  DWIDTH  write data to backing memory.
- mm_rdata  in  DWIDTH  read data from backing memory.
- mm_ack  in  1  one-cycle completion pulse; on reads, mm_rdata is valid in the same cycle.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS) word-offset bits above bit 0.
  - IDX = log2(NUM_SETS) bits above the offset.
  - Tag is the remaining upper bits.
- Storage: internal arrays valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS][LINE_WORDS].
- Reset (rst = 0, async):
  - all valid bits cleared; state = IDLE.
  - mm_req = 0, mm_we = 0, mm_addr = 0, mm_wdata = 0.
  - data_out = 0, cache_miss_stall = 0.
  - Data/tag arrays are not reset.
- hit = valid[idx] && tag[idx] == addr tag.
- Outputs:
  - data_out is combinational: data[idx][off] when a read hits in IDLE, otherwise 0.
  - cache_miss_stall is combinational: 1 when mem_en && (mem_write || (mem_read && !hit)) in IDLE, and 1 throughout FILL and WTHRU.
- States: IDLE, FILL, WTHRU.
- IDLE:
  - mem_en = 0, or neither read nor write: no action, stall = 0.
  - Read hit: data returned the same cycle, stall = 0, zero-latency.
  - Read miss: next state FILL; fill counter = 0; line base = {tag, idx, 0}.
  - Write (hit or miss): next state WTHRU; latch address and data.
- FILL:
  - mm_req = 1, mm_we = 0, mm_addr = line base + 2*counter.
  - Exactly one outstanding request at a time.
  - On mm_ack: data[idx][counter] ← mm_rdata; counter++; mm_req may stay high for the next word.
  - On the ack of word LINE_WORDS-1: valid[idx] ← 1, tag[idx] ← tag, next state IDLE.
  - In IDLE the request is re-evaluated; it now hits, so stall drops in that IDLE cycle.
  - Miss latency = sum of per-word ack latencies + 1 cycle.
- WTHRU:
  - mm_req = 1, mm_we = 1, mm_addr = latched address, mm_wdata = latched data.
  - On mm_ack: if the latched address hit, update data[idx][off]; next state IDLE.
  - One cycle later stall is 0 unless a new write is present.
  - A miss does not allocate.
- Valid bit is set only after the last fill word. A reset mid-FILL leaves the line invalid, and refetch occurs on the next access.
- Simultaneous mem_read and mem_write: treated as a write.
- mm_ack while in IDLE: ignored.
- Top-of-memory addresses (e.g. 0xFFFE) map normally. The fill address wraps only within the line: base + offset never carries into the index.
- Changes to addr_in, data_in or the mem_* controls while stall = 1 are a protocol violation. The latched values are used.

Test Plan:
- Read miss then hit at 0x0010, default params, mm_ack 2 cycles after each mm_req. Required:
  - mm_addr steps 0x0010 through 0x001E.
  - stall is high for 8×3 cycles plus the IDLE cycle.
  - The next read of 0x0014 returns the filled word with stall = 0.
- Write 0xABCD to 0xFFFE (miss). Required:
  - mm_we = 1, mm_addr = 0xFFFE, mm_wdata = 0xABCD.
  - stall drops after mm_ack.
  - A following read of 0xFFFE misses and fills 0xFFF0–0xFFFE, returning 0xABCD.
- Write hit 0x1234 to 0x0012 after the fill. Required: memory is written, and a read of 0x0012 returns 0x1234 with 0 stall cycles.
- Conflict: read 0x0010, then 0x0210 (same idx, different tag), then 0x0010. Required: three full fills; the tag array is replaced each time.
- Assert rst = 0 during FILL word 4. Required:
  - mm_req = 0 immediately (async); state IDLE.
  - Re-reading 0x0010 misses and refetches all 8 words.
- LINE_WORDS = 4, NUM_SETS = 8, mem_read and mem_write both 1 at 0x0006. Required: handled as a write-through, and the fill burst is 4 words.

Source files
------------

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Talks to backing memory over a one-outstanding req/ack handshake with variable latency.
module cache_ctrl_dm #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 16,
  parameter int LINE_WORDS = 8,
  parameter int NUM_SETS   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              cache_miss_stall,
  output logic              mm_req,
  output logic              mm_we,
  output logic [AWIDTH-1:0] mm_addr,
  output logic [DWIDTH-1:0] mm_wdata,
  input  logic [DWIDTH-1:0] mm_rdata,
  input  logic              mm_ack
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(NUM_SETS);
  localparam int TAGW = AWIDTH - 1 - OFF - IDX;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WTHRU} state_t;

  state_t            state_reg, state_next;
  logic [OFF-1:0]    cnt_reg, cnt_next;
  logic [AWIDTH-1:0] lat_addr_reg, lat_addr_next;
  logic [DWIDTH-1:0] lat_data_reg, lat_data_next;

  logic [NUM_SETS-1:0] valid_vec;
  logic [TAGW-1:0]     tag_mem  [NUM_SETS];
  logic [DWIDTH-1:0]   data_mem [NUM_SETS*LINE_WORDS];

  logic [OFF-1:0]  in_off, lat_off;
  logic [IDX-1:0]  in_idx, lat_idx;
  logic [TAGW-1:0] in_tag, lat_tag;
  logic            in_hit, lat_hit;
  logic            fill_we, wthru_we, line_done;
  logic            unused_bits;

  assign in_off  = addr_in[OFF:1];
  assign in_idx  = addr_in[OFF+IDX:OFF+1];
  assign in_tag  = addr_in[AWIDTH-1:OFF+IDX+1];
  assign lat_off = lat_addr_reg[OFF:1];
  assign lat_idx = lat_addr_reg[OFF+IDX:OFF+1];
  assign lat_tag = lat_addr_reg[AWIDTH-1:OFF+IDX+1];

  assign in_hit  = valid_vec[in_idx] && (tag_mem[in_idx] == in_tag);
  assign lat_hit = valid_vec[lat_idx] && (tag_mem[lat_idx] == lat_tag);

  assign unused_bits = ^{addr_in[0], lat_addr_reg[0]};

  // Valid bits are the only part of the storage that is cleared by reset.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_valid
      logic v_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_reg <= 1'b0;
        end else if (line_done && (lat_idx == IDX'(gi))) begin
          v_reg <= 1'b1;
        end
      end
      assign valid_vec[gi] = v_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[{lat_idx, cnt_reg}] <= mm_rdata;
    end
    if (wthru_we) begin
      data_mem[{lat_idx, lat_off}] <= lat_data_reg;
    end
    if (line_done) begin
      tag_mem[lat_idx] <= lat_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      lat_addr_reg <= '0;
      lat_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      lat_addr_reg <= lat_addr_next;
      lat_data_reg <= lat_data_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    lat_addr_next    = lat_addr_reg;
    lat_data_next    = lat_data_reg;
    data_out         = '0;
    cache_miss_stall = 1'b0;
    mm_req           = 1'b0;
    mm_we            = 1'b0;
    mm_addr          = '0;
    mm_wdata         = '0;
    fill_we          = 1'b0;
    wthru_we         = 1'b0;
    line_done        = 1'b0;
    // Outputs are held at zero for as long as reset is asserted.
    if (rst) begin
      case (state_reg)
        ST_IDLE: begin
          if (mem_en && mem_write) begin
            cache_miss_stall = 1'b1;
            state_next       = ST_WTHRU;
            lat_addr_next    = addr_in;
            lat_data_next    = data_in;
          end else if (mem_en && mem_read) begin
            if (in_hit) begin
              data_out = data_mem[{in_idx, in_off}];
            end else begin
              cache_miss_stall = 1'b1;
              state_next       = ST_FILL;
              cnt_next         = '0;
              lat_addr_next    = addr_in;
            end
          end
        end
        ST_FILL: begin
          cache_miss_stall = 1'b1;
          mm_req           = 1'b1;
          // Offset field is replaced, so the burst never carries into the index.
          mm_addr          = {lat_addr_reg[AWIDTH-1:OFF+1], cnt_reg, 1'b0};
          if (mm_ack) begin
            fill_we  = 1'b1;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == OFF'(LINE_WORDS - 1)) begin
              line_done  = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        ST_WTHRU: begin
          cache_miss_stall = 1'b1;
          mm_req           = 1'b1;
          mm_we            = 1'b1;
          mm_addr          = {lat_addr_reg[AWIDTH-1:1], 1'b0};
          mm_wdata         = lat_data_reg;
          if (mm_ack) begin
            wthru_we   = lat_hit;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule
